// File: rtl/asyn_fifo_wr_arb.sv
// asyn_fifo_wr_arb: round-robin arbiter sharing the asyn_fifo write port among
// N_REQ packet sources in the wclk domain. A grant is held for a whole packet
// and released on the owner's last beat; wfull back-pressures the owner.
// Optional feature macro: ASYN_FIFO_WR_ARB_MAXBURST_EN caps every grant at
// MAX_BURST beats, splitting long packets across grants.
//
// state | meaning
// IDLE  | no owner; next owner is picked scanning upward from rr_ptr
// LOCK  | one requester owns the FIFO write port until last (or burst cap)
module asyn_fifo_wr_arb #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                        wclk,
  input  logic                        wrst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        winc,
  output logic [DATA_WIDTH-1:0]       wdata,
  input  logic                        wfull,
  output logic [N_REQ-1:0]            grant,
  output logic                        busy
);

  localparam int PTR_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 1) begin : g_param_check
    $error("asyn_fifo_wr_arb: parameter out of range");
  end

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner_idx;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] next_ptr;
  logic             pick_found;
  logic             own_valid;
  logic             own_last;
  logic             xfer;
  logic             release_grant;

  // Route the current owner's valid/last/data; everything reads zero with no owner.
  always_comb begin
    owner_idx = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    wdata     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        owner_idx = PTR_W'(i);
        own_valid = req_valid[i];
        own_last  = req_last[i];
        wdata     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A beat on the reset edge must not reach the FIFO, so wrst also gates the handshake.
  assign xfer      = own_valid & ~wfull & ~wrst;
  assign winc      = xfer;
  assign req_ready = grant & {N_REQ{~wfull & ~wrst}};
  assign next_ptr  = (owner_idx == PTR_W'(N_REQ-1)) ? '0 : owner_idx + PTR_W'(1);

  // Round-robin pick: scan offsets high to low so the smallest offset from rr_ptr wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(idx);
      end
    end
  end

`ifdef ASYN_FIFO_WR_ARB_MAXBURST_EN
  localparam int CNT_W = $clog2(MAX_BURST+1);

  logic [CNT_W-1:0] beat_cnt;
  logic             burst_hit;

  assign burst_hit     = (beat_cnt == CNT_W'(MAX_BURST-1));
  assign release_grant = xfer & (own_last | burst_hit);

  // Count beats of the current grant; cleared whenever the grant is released.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      beat_cnt <= '0;
    end else if (release_grant) begin
      beat_cnt <= '0;
    end else if (xfer) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end
`else
  assign release_grant = xfer & own_last;
`endif

  // Arbitration FSM: load a one-hot grant from IDLE, release it on last beat.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state  <= IDLE;
      grant  <= '0;
      busy   <= 1'b0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state <= LOCK;
            grant <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
            busy  <= 1'b1;
          end
        end
        LOCK: begin
          if (release_grant) begin
            state  <= IDLE;
            grant  <= '0;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_asyn_fifo_wr_arb.sv
// Testbench for asyn_fifo_wr_arb: packet sources modelled as per-requester
// beat queues, expected FIFO words held in a scoreboard queue.
module tb_asyn_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic             wclk;
  logic             wrst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             winc;
  logic [DW-1:0]    wdata;
  logic             wfull;
  logic [NR-1:0]    grant;
  logic             busy;

  asyn_fifo_wr_arb #(.N_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .winc      (winc),
    .wdata     (wdata),
    .wfull     (wfull),
    .grant     (grant),
    .busy      (busy)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [DW:0]   src_q [NR][$];
  logic [DW-1:0] exp_q [$];
  int            wcyc_q [$];
  logic [NR-1:0] wgnt_q [$];

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            n_beats = 0;
  int            n_full  = 0;
  bit            chk_idle = 1'b0;
  logic [NR-1:0] full_gnt = '0;
  int            stall_at = -1;
  int            stall_len = 0;
  int            stall_left = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_inputs();
    logic [DW:0] b;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        b = src_q[i][0];
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = b[DW-1:0];
        req_last[i]           = b[DW];
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*DW +: DW]  = '0;
        req_last[i]           = 1'b0;
      end
    end
  endtask

  task automatic push_pkt(input int r, input logic [DW-1:0] base, input int len);
    for (int b = 0; b < len; b++)
      src_q[r].push_back({(b == len-1), base + DW'(b)});
  endtask

  task automatic push_exp(input logic [DW-1:0] base, input int len);
    for (int b = 0; b < len; b++)
      exp_q.push_back(base + DW'(b));
  endtask

  // One clock: sample at negedge, update sources and drive at posedge+1.
  task automatic cycle();
    logic [NR-1:0] fired;
    logic [DW-1:0] e;
    @(negedge wclk);
    fired = req_valid & req_ready;
    if (chk_idle) begin
      chk("idle_grant", grant, 0);
      chk("idle_winc", winc, 0);
      chk("idle_ready", req_ready, 0);
      chk("idle_wdata", wdata, 0);
    end
    if (wfull) begin
      n_full++;
      chk("full_winc", winc, 0);
      chk("full_ready", req_ready, 0);
      if (full_gnt != '0) chk("full_grant", grant, full_gnt);
    end
    if (winc) begin
      n_beats++;
      wcyc_q.push_back(cyc);
      wgnt_q.push_back(grant);
      chk("xfer_owner", fired, grant);
      if (exp_q.size() == 0) begin
        chk("unexpected_winc", winc, 0);
      end else begin
        e = exp_q.pop_front();
        chk("wdata", wdata, e);
      end
    end
    @(posedge wclk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++)
      if (fired[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    if (stall_at >= 0 && n_beats == stall_at) begin
      stall_left = stall_len;
      stall_at   = -1;
    end
    wfull = (stall_left > 0);
    if (stall_left > 0) stall_left--;
    drive_inputs();
  endtask

  function automatic bit src_pending();
    bit p;
    p = 1'b0;
    for (int i = 0; i < NR; i++)
      if (src_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic run_drain(input int budget);
    int used;
    used = 0;
    while ((exp_q.size() > 0 || src_pending()) && used < budget) begin
      cycle();
      used++;
    end
    cycle();
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    cycle();
    cycle();
    wrst = 1'b0;
    n_beats = 0;
    n_full  = 0;
    wcyc_q.delete();
    wgnt_q.delete();
  endtask

  initial begin
    int used;
    wrst      = 1'b1;
    wfull     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;

    // Reset with all requesters valid, then round robin of single-beat packets
    push_pkt(0, 32'hA0, 1);
    push_pkt(1, 32'hA1, 1);
    push_pkt(2, 32'hA2, 1);
    push_pkt(3, 32'hA3, 1);
    push_pkt(0, 32'hA0, 1);
    exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0};
    drive_inputs();
    chk_idle = 1'b1;
    repeat (3) cycle();
    chk_idle = 1'b0;
    wrst = 1'b0;
    cycle();
    chk("grant_after_rst", grant, 4'b0001);
    chk("busy_after_rst", busy, 1);
    run_drain(40);
    chk("rr_n_winc", wcyc_q.size(), 5);
    for (int k = 1; k < wcyc_q.size(); k++)
      chk("rr_gap", wcyc_q[k] - wcyc_q[k-1], 2);

    // Packet lock: req0 5 beats while req1 waits
    do_reset();
    push_pkt(0, 32'h1, 5);
    push_pkt(1, 32'hB1, 1);
    push_exp(32'h1, 5);
    push_exp(32'hB1, 1);
    drive_inputs();
    run_drain(40);
    chk("lock_n_winc", wcyc_q.size(), 6);
    for (int k = 1; k < 5 && k < wcyc_q.size(); k++)
      chk("lock_gap", wcyc_q[k] - wcyc_q[k-1], 1);
    if (wcyc_q.size() > 5) chk("lock_bubble", wcyc_q[5] - wcyc_q[4], 2);
    if (wgnt_q.size() > 5) begin
      chk("lock_first_owner", wgnt_q[0], 4'b0001);
      chk("lock_next_owner", wgnt_q[5], 4'b0010);
    end

    // Full stall: wfull for 3 cycles after beat 2
    do_reset();
    push_pkt(0, 32'h11, 5);
    push_exp(32'h11, 5);
    stall_at  = 2;
    stall_len = 3;
    full_gnt  = 4'b0001;
    drive_inputs();
    run_drain(40);
    full_gnt = '0;
    chk("stall_full_cycles", n_full, 3);
    chk("stall_n_winc", wcyc_q.size(), 5);
    if (wcyc_q.size() > 2) chk("stall_gap", wcyc_q[2] - wcyc_q[1], 4);

    // Long packet from req0 against a single beat from req1
    do_reset();
    push_pkt(0, 32'h21, 10);
    push_pkt(1, 32'h31, 1);
`ifdef ASYN_FIFO_WR_ARB_MAXBURST_EN
    push_exp(32'h21, 4);
    push_exp(32'h31, 1);
    push_exp(32'h25, 4);
    push_exp(32'h29, 2);
`else
    push_exp(32'h21, 10);
    push_exp(32'h31, 1);
`endif
    drive_inputs();
    run_drain(80);
    chk("burst_n_winc", wcyc_q.size(), 11);
`ifdef ASYN_FIFO_WR_ARB_MAXBURST_EN
    if (wgnt_q.size() > 4) chk("burst_split_owner", wgnt_q[4], 4'b0010);
`else
    if (wgnt_q.size() > 10) chk("burst_last_owner", wgnt_q[10], 4'b0010);
`endif

    // Mid-packet reset: move rr_ptr away from 0 first, then abort on beat 3
    do_reset();
    push_pkt(2, 32'h52, 1);
    push_exp(32'h52, 1);
    drive_inputs();
    run_drain(20);
    n_beats = 0;
    push_pkt(0, 32'h41, 5);
    push_exp(32'h41, 5);
    drive_inputs();
    used = 0;
    while (n_beats < 2 && used < 20) begin
      cycle();
      used++;
    end
    chk("beats_before_rst", n_beats, 2);
    exp_q.delete();
    wrst = 1'b1;
    cycle();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    wrst = 1'b0;
    src_q[0].delete();
    push_pkt(0, 32'h41, 5);
    push_pkt(3, 32'h53, 1);
    push_exp(32'h41, 5);
    push_exp(32'h53, 1);
    wgnt_q.delete();
    drive_inputs();
    run_drain(40);
    if (wgnt_q.size() > 0) chk("restart_owner", wgnt_q[0], 4'b0001);
    chk("restart_n_winc", wgnt_q.size(), 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
